// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction prefetch queue. Streams sequential fetches from an
//            instruction memory with one-cycle read latency into a small
//            FIFO of (instruction, pc) pairs, and flushes on jump.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_rd,
    input  logic [INSTR_W-1:0]       imem_data,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     jump,
    input  logic [ADDR_W-1:0]        jump_target,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Capacity expressed at the width of the occupancy-plus-inflight sum.
    localparam logic [LVL_W:0] CAPACITY = (LVL_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   fetch_pc;
    logic                inflight;     // a strobe issued last cycle whose word is still wanted
    logic [ADDR_W-1:0]   inflight_pc;  // address of that strobe, used as the tag on push
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    count;

    logic [INSTR_W-1:0]  q_instr [DEPTH];
    logic [ADDR_W-1:0]   q_pc    [DEPTH];

    logic                fetch;
    logic                push;
    logic                pop;
    logic [LVL_W:0]      demand;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE and FLUSH are single-cycle; jump wins from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
        if (jump) begin
            state_nxt = S_FLUSH;
        end
    end

    // Fetch throttle and handshake decode. The throttle counts the word still
    // in flight so a full queue can never be overrun by the memory pipeline.
    always_comb begin
        demand      = {1'b0, count} + {{LVL_W{1'b0}}, inflight};
        fetch       = (state == S_RUN) && (demand < CAPACITY);
        instr_valid = (state == S_RUN) && (count != '0);
        push        = inflight && (state == S_RUN) && !jump;
        pop         = instr_valid && instr_ready;
        imem_rd     = fetch;
        imem_addr   = fetch_pc;
        level       = count;
        instr_out   = instr_valid ? q_instr[rd_ptr] : '0;
        instr_pc    = instr_valid ? q_pc[rd_ptr]    : '0;
    end

    // Pointers, occupancy, fetch address and in-flight tracking. A jump
    // drops everything queued or in flight and redirects the fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (jump) begin
            fetch_pc    <= jump_target;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= fetch;
            if (fetch) begin
                fetch_pc    <= fetch_pc + 1'b1;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are only observable through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_data;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue with a one-cycle
//            latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [7:0]  jump_target;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fails  = 0;
    logic watch  = 1'b0;
    logic bad_seen = 1'b0;

    fetch_queue #(.DEPTH(4), .ADDR_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_target (jump_target),
        .level       (level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // Memory returns the word for the address strobed on the previous edge.
    always @(posedge clk) begin
        imem_data <= imem_rd ? mem_word(imem_addr) : 16'hDEAD;
    end

    // Watch for any address in 0x10..0x1F being fetched or presented.
    always @(negedge clk) begin
        if (watch && ((imem_rd && imem_addr[7:4] == 4'h1) ||
                      (instr_valid && instr_pc[7:4] == 4'h1))) begin
            bad_seen = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_target = 8'h00;
        step(); step();
        // Reset state
        check("rst_rd",    32'(imem_rd), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out",   32'(instr_out), 32'd0);
        check("rst_pc",    32'(instr_pc), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        // Reset then stall
        rst = 1'b0;
        check("idle_rd", 32'(imem_rd), 32'd0);
        step();
        check("c2_rd", 32'(imem_rd), 32'd1);
        check("c2_addr", 32'(imem_addr), 32'h00);
        check("c2_valid", 32'(instr_valid), 32'd0);
        step();
        check("c3_rd", 32'(imem_rd), 32'd1);
        check("c3_addr", 32'(imem_addr), 32'h01);
        check("c3_valid", 32'(instr_valid), 32'd0);
        step();
        check("c4_addr", 32'(imem_addr), 32'h02);
        check("c4_valid", 32'(instr_valid), 32'd1);
        check("c4_pc", 32'(instr_pc), 32'h00);
        check("c4_out", 32'(instr_out), 32'(mem_word(8'h00)));
        check("c4_level", 32'(level), 32'd1);
        step();
        check("c5_rd", 32'(imem_rd), 32'd1);
        check("c5_addr", 32'(imem_addr), 32'h03);
        check("c5_level", 32'(level), 32'd2);
        step();
        check("c6_rd", 32'(imem_rd), 32'd0);
        check("c6_level", 32'(level), 32'd3);
        step();
        check("c7_rd", 32'(imem_rd), 32'd0);
        check("c7_level", 32'(level), 32'd4);
        step();
        check("stall_rd", 32'(imem_rd), 32'd0);
        check("stall_level", 32'(level), 32'd4);
        check("stall_pc", 32'(instr_pc), 32'h00);
        check("stall_out", 32'(instr_out), 32'(mem_word(8'h00)));

        // Streaming: one instruction per cycle, consecutive pcs
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_pc", 32'(instr_pc), 32'(k));
            check("stream_lvl_max", 32'(level <= 3'd4), 32'd1);
            step();
        end

        // Refill to 4, then pop one to leave 3 queued with a strobe pending
        instr_ready = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("refill_level", 32'(level), 32'd4);
        check("refill_pc", 32'(instr_pc), 32'd12);
        instr_ready = 1'b1;
        step();
        check("three_level", 32'(level), 32'd3);
        check("three_rd", 32'(imem_rd), 32'd1);
        check("three_pc", 32'(instr_pc), 32'd13);

        // Jump with 3 queued and one word in flight
        instr_ready = 1'b0; jump = 1'b1; jump_target = 8'h40;
        step();
        jump = 1'b0;
        check("jmp_level", 32'(level), 32'd0);
        check("jmp_rd", 32'(imem_rd), 32'd0);
        check("jmp_valid", 32'(instr_valid), 32'd0);
        step();
        check("jmp_addr_rd", 32'(imem_rd), 32'd1);
        check("jmp_addr", 32'(imem_addr), 32'h40);
        check("jmp_valid2", 32'(instr_valid), 32'd0);
        step();
        check("jmp_valid3", 32'(instr_valid), 32'd0);
        step();
        check("jmp_head_valid", 32'(instr_valid), 32'd1);
        check("jmp_head_pc", 32'(instr_pc), 32'h40);
        check("jmp_head_out", 32'(instr_out), 32'(mem_word(8'h40)));

        // Wrap of the fetch address
        instr_ready = 1'b1; jump = 1'b1; jump_target = 8'hFE;
        step();
        jump = 1'b0;
        check("wrap_flush_valid", 32'(instr_valid), 32'd0);
        step();
        check("wrap_addr", 32'(imem_addr), 32'hFE);
        step();
        check("wrap_addr2", 32'(imem_addr), 32'hFF);
        step();
        check("wrap_pc0", 32'(instr_pc), 32'hFE);
        step();
        check("wrap_pc1", 32'(instr_pc), 32'hFF);
        step();
        check("wrap_pc2", 32'(instr_pc), 32'h00);
        step();
        check("wrap_pc3", 32'(instr_pc), 32'h01);
        check("wrap_out3", 32'(instr_out), 32'(mem_word(8'h01)));

        // Back-to-back jumps
        watch = 1'b1;
        jump = 1'b1; jump_target = 8'h10;
        step();
        jump_target = 8'h20;
        step();
        jump = 1'b0;
        check("b2b_valid", 32'(instr_valid), 32'd0);
        check("b2b_rd", 32'(imem_rd), 32'd0);
        step();
        check("b2b_addr", 32'(imem_addr), 32'h20);
        step();
        step();
        check("b2b_head_valid", 32'(instr_valid), 32'd1);
        check("b2b_head_pc", 32'(instr_pc), 32'h20);
        for (int k = 0; k < 4; k++) step();
        watch = 1'b0;
        check("b2b_no_stale", 32'(bad_seen), 32'd0);

        // Mid-fill reset
        instr_ready = 1'b0; jump = 1'b1; jump_target = 8'h00;
        step();
        jump = 1'b0;
        step(); step(); step(); step();
        check("mid_level2", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_rd", 32'(imem_rd), 32'd0);
        check("mid_rst_out", 32'(instr_out), 32'd0);
        step();
        rst = 1'b0;
        check("re_idle_rd", 32'(imem_rd), 32'd0);
        step();
        check("re_c2_rd", 32'(imem_rd), 32'd1);
        check("re_c2_addr", 32'(imem_addr), 32'h00);
        step();
        check("re_c3_valid", 32'(instr_valid), 32'd0);
        step();
        check("re_c4_valid", 32'(instr_valid), 32'd1);
        check("re_c4_pc", 32'(instr_pc), 32'h00);
        check("re_c4_level", 32'(level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
